udma_i2s_rx_packer: RTL
=======================

Name: udma_i2s_rx_packer

Overview:
- Sits between the I2S RX dual-clock FIFO output (sys_clk domain) and the uDMA RX channel data port.
- Packs LSB-aligned 8-bit or 16-bit audio samples into full 32-bit words, little-endian, so L2 bandwidth is not wasted on padded samples.
- 32-bit mode is a registered pass-through.
- Supports flush of a partial word (zero-padded) and clean disable.

Parameters:
- DATA_WIDTH, 32, width of input sample bus and output word; only 32 supported.

Ports:
- sys_clk_i  in  1  system clock
- sys_rst_i  in  1  synchronous active-high reset
- cfg_en_i  in  1  packer enable; low = not accepting input, partial word discarded
- cfg_sample_size_i  in  2  00=8b, 01=16b, 10=32b, 11=reserved (treated as 32b)
- cfg_flush_i  in  1  single-cycle pulse: emit pending partial word
- in_data_i  in  32  sample, LSB-aligned
- in_valid_i  in  1  sample valid
- in_ready_o  out  1  sample accepted when valid&ready
- out_data_o  out  32  packed word to uDMA
- out_valid_o  out  1  word valid
- out_ready_i  in  1  uDMA ready
- out_datasize_o  out  2  constant 2'b10 (32-bit transfers)
- sts_lanes_o  out  2  samples currently held in accumulator
- sts_flush_busy_o  out  1  flush requested, not yet emitted

Behaviour:
- One clock, sys_clk_i. Reset is synchronous and active-high (sys_rst_i). All state clears on reset.
- Reset values:
  - out_valid_o=0, out_data_o=0, in_ready_o=0
  - sts_lanes_o=0, sts_flush_busy_o=0, out_datasize_o=2'b10
- Lanes per word N: 4 (8b), 2 (16b), 1 (32b).
- Size is latched into size_q whenever lane count is 0 and a sample is accepted. Changes while lanes>0 take effect from the next word.
- Sample k of a word goes to bits [k*W +: W], W=8/16/32. Upper input bits above W are ignored.
- Accumulator bits not yet written are 0.
- Output register: a single stage.
  - Loads when the last lane is accepted, or a flush fires.
  - Holds while out_valid_o & ~out_ready_i; clears valid on handshake.
- Latency: sample completing a word accepted in cycle T -> out_valid_o=1 in T+1.
- in_ready_o = cfg_en_i & ~flush_pend & ~(last_lane & out_valid_o & ~out_ready_i).
  - Non-completing samples are always accepted while enabled.
  - in_ready_o is combinational from state and out_ready_i. No dependency on in_valid_i.
- FSM:
  - DISABLED:
    - in_ready_o=0.
    - Accumulator and lane count cleared.
    - Output register still drains.
    - -> PACK when cfg_en_i=1.
  - PACK:
    - Normal packing.
    - cfg_flush_i with lanes>0 -> FLUSH if output register free (or freeing this cycle), else FLUSH_WAIT.
    - cfg_flush_i with lanes=0 is ignored.
    - cfg_en_i=0 -> DISABLED, partial word discarded.
  - FLUSH_WAIT:
    - sts_flush_busy_o=1, in_ready_o=0.
    - -> FLUSH when the output register frees.
    - cfg_en_i=0 -> DISABLED, flush cancelled.
  - FLUSH:
    - Loads the zero-padded partial word into the output register.
    - Clears lanes.
    - -> PACK in one cycle.
- Simultaneous sample accept and cfg_flush_i in PACK:
  - The sample is included first.
  - If it completes the word, that word is emitted normally and the flush has nothing left (no extra output).
- cfg_flush_i while in DISABLED or FLUSH_WAIT: ignored.
- 32b mode: every accepted sample produces one word. Flush never has pending data.
- Reset mid-word or mid-flush: all data dropped, no output emitted.

Decomposition:
- Shared package udma_i2s_pkg:
  - sample-size encodings (SZ_8, SZ_16, SZ_32)
  - packer FSM state enum (DISABLED, PACK, FLUSH_WAIT, FLUSH)
  - constant DATASIZE_WORD=2'b10
- No sub-module; the output register is inline.
- Optional reuse of the existing generic skid stage is not required.

Test Plan:
- 8b mode, out_ready=1:
  - Feed 0x11,0x22,0x33,0x44 back-to-back -> one word 0x44332211, valid 1 cycle after 4th accept.
  - sts_lanes sequence 1,2,3,0.
- 16b mode: feed 0xAAAA1234, 0x0000BEEF -> word 0xBEEF1234 (upper input bits ignored).
- Backpressure, 8b, out_ready=0 with one word held:
  - 3 samples accepted.
  - 4th sample: in_ready=0 until out_ready=1.
  - Next word correct, no loss or duplication.
- Flush, 8b after samples 0xA1,0xB2:
  - cfg_flush pulse -> word 0x0000B2A1, lanes=0.
  - Flush with lanes=0 -> no output.
- Flush while output occupied:
  - sts_flush_busy=1, in_ready=0 until drained.
  - Then partial word emitted.
- Disable/reset mid-word:
  - 16b, one sample held, cfg_en=0 -> no output, lanes=0.
  - Re-enable, feed 0x1,0x2 -> 0x00020001.
  - sys_rst_i asserted mid-word -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/udma_i2s_pkg.sv
// ============================================================================
// Module   : udma_i2s_pkg
// Purpose  : Shared encodings for the uDMA I2S RX packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package udma_i2s_pkg;

  localparam logic [1:0] SZ_8  = 2'b00;
  localparam logic [1:0] SZ_16 = 2'b01;
  localparam logic [1:0] SZ_32 = 2'b10;

  localparam logic [1:0] DISABLED   = 2'd0;
  localparam logic [1:0] PACK       = 2'd1;
  localparam logic [1:0] FLUSH_WAIT = 2'd2;
  localparam logic [1:0] FLUSH      = 2'd3;

  localparam logic [1:0] DATASIZE_WORD = 2'b10;

  typedef logic [1:0] pack_state_t;

  // Reserved encoding 2'b11 behaves as 32-bit.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_32 : sz;
  endfunction

  // Index of the lane that completes a word for the given size.
  function automatic logic [1:0] last_lane_idx(input logic [1:0] sz);
    case (sz)
      SZ_8:    return 2'd3;
      SZ_16:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/udma_i2s_rx_packer.sv
// ============================================================================
// Module   : udma_i2s_rx_packer
// Purpose  : Packs 8/16-bit LSB-aligned I2S samples into 32-bit words for uDMA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module udma_i2s_rx_packer
  import udma_i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  cfg_en_i,
  input  logic [1:0]            cfg_sample_size_i,
  input  logic                  cfg_flush_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            out_datasize_o,
  output logic [1:0]            sts_lanes_o,
  output logic                  sts_flush_busy_o
);

  pack_state_t           state_q, state_d;
  logic [1:0]            lanes_q, lanes_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic [1:0]            eff_size;
  logic                  last_lane;
  logic                  out_free;
  logic                  in_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] masked;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] merged;

  // A new word takes its size from config; a word in progress keeps its latched size.
  assign eff_size  = (lanes_q == 2'd0) ? norm_size(cfg_sample_size_i) : size_q;
  assign last_lane = (lanes_q == last_lane_idx(eff_size));
  assign out_free  = ~out_valid_q | out_ready_i;
  assign in_ready  = cfg_en_i & (state_q == PACK) & ~(last_lane & out_valid_q & ~out_ready_i);
  assign accept    = in_valid_i & in_ready;

  always_comb begin
    masked = in_data_i;
    shamt  = 5'd0;
    case (eff_size)
      SZ_8: begin
        masked = {{(DATA_WIDTH-8){1'b0}}, in_data_i[7:0]};
        shamt  = {lanes_q, 3'b000};
      end
      SZ_16: begin
        masked = {{(DATA_WIDTH-16){1'b0}}, in_data_i[15:0]};
        shamt  = {lanes_q[0], 4'b0000};
      end
      default: begin
        masked = in_data_i;
        shamt  = 5'd0;
      end
    endcase
    merged = acc_q | (masked << shamt);
  end

  always_comb begin
    state_d     = state_q;
    lanes_d     = lanes_q;
    size_d      = size_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      DISABLED: begin
        acc_d   = '0;
        lanes_d = 2'd0;
        if (cfg_en_i) state_d = PACK;
      end
      PACK: begin
        if (!cfg_en_i) begin
          state_d = DISABLED;
          acc_d   = '0;
          lanes_d = 2'd0;
        end else begin
          if (accept) begin
            size_d = eff_size;
            if (last_lane) begin
              out_data_d  = merged;
              out_valid_d = 1'b1;
              acc_d       = '0;
              lanes_d     = 2'd0;
            end else begin
              acc_d   = merged;
              lanes_d = lanes_q + 2'd1;
            end
          end
          // The sample accepted this cycle is counted before deciding if the flush has data.
          if (cfg_flush_i && (lanes_d != 2'd0)) begin
            state_d = out_free ? FLUSH : FLUSH_WAIT;
          end
        end
      end
      FLUSH_WAIT: begin
        if (!cfg_en_i) begin
          state_d = DISABLED;
          acc_d   = '0;
          lanes_d = 2'd0;
        end else if (out_free) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        out_data_d  = acc_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
        lanes_d     = 2'd0;
        state_d     = PACK;
      end
      default: begin
        state_d = DISABLED;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= DISABLED;
      lanes_q     <= 2'd0;
      size_q      <= SZ_8;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      size_q      <= size_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o       = in_ready;
  assign out_data_o       = out_data_q;
  assign out_valid_o      = out_valid_q;
  assign out_datasize_o   = DATASIZE_WORD;
  assign sts_lanes_o      = lanes_q;
  assign sts_flush_busy_o = (state_q == FLUSH_WAIT) || (state_q == FLUSH);

endmodule

`default_nettype wire
